// File: rtl/pcie_ss_axis_pkg.sv
// Shared types for the PCIe subsystem FLR request/response channel.
//   t_flr_tdata      payload of one FLR message (function id + reserved bit)
//   t_axis_pcie_flr  AXI-S style beat: tvalid + tdata
//   t_flr_req        the part of a request that is queued and echoed back
//   e_flr_rsp_state  FSM states of the FLR responder
//   flr_func_in_range  true when a request addresses an existing function
package pcie_ss_axis_pkg;

  localparam int FLR_PF_W = 3;
  localparam int FLR_VF_W = 11;

  typedef struct packed {
    logic                rsvd;
    logic                vf_active;
    logic [FLR_VF_W-1:0] vf;
    logic [FLR_PF_W-1:0] pf;
  } t_flr_tdata;

  typedef struct packed {
    logic       tvalid;
    t_flr_tdata tdata;
  } t_axis_pcie_flr;

  typedef struct packed {
    logic                vf_active;
    logic [FLR_VF_W-1:0] vf;
    logic [FLR_PF_W-1:0] pf;
  } t_flr_req;

  localparam int FLR_REQ_W = $bits(t_flr_req);

  typedef enum logic [1:0] {
    FLR_IDLE   = 2'd0,
    FLR_ASSERT = 2'd1,
    FLR_DRAIN  = 2'd2,
    FLR_RESP   = 2'd3
  } e_flr_rsp_state;

  function automatic logic flr_func_in_range(input t_flr_req req,
                                             input int       num_pf,
                                             input int       num_vf);
    logic pf_ok;
    logic vf_ok;
    pf_ok = int'(req.pf) < num_pf;
    vf_ok = !req.vf_active || (int'(req.vf) < num_vf);
    return pf_ok && vf_ok;
  endfunction

endpackage

// File: rtl/pcie_flr_req_fifo.sv
// Show-ahead synchronous FIFO holding pending FLR requests.
//   avl_clk  clock
//   rst_n    synchronous active-low reset (pointers only; storage is not reset)
//   wdata    entry to write
//   wreq     write request; taken when not full, or when full and a read
//            happens in the same cycle
//   rdack    read acknowledge; pops the head shown on rdata
//   rdata    current head entry (valid while empty=0)
//   empty    no entries
//   full     2**DEPTH_LOG2 entries stored
module pcie_flr_req_fifo #(
  parameter int WIDTH      = 15,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             avl_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wreq,
  input  logic             rdack,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_wr;
  logic                do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  assign do_rd = rdack && !empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign do_wr = wreq && (!full || do_rd);

  assign rdata = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge avl_clk) begin
    if (do_wr) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end
  end

  always_ff @(posedge avl_clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_flr_responder.sv
// FIM-side endpoint of the FLR request/response channel.
// Queues incoming PF/VF FLR requests, resets the target function, waits for it
// to go idle (or times out) and returns one completion echoing pf/vf/vf_active.
//   avl_clk       clock
//   rst_n         synchronous active-low reset
//   flr_req_if    FLR request beat, taken whenever tvalid=1 (no backpressure)
//   flr_rsp_if    FLR completion beat, tvalid is a one-cycle pulse
//   pf_flr_rst_n  per-PF function reset, active-low
//   vf_flr_rst    VF reset active, qualifies vf_flr_pf / vf_flr_vf
//   vf_flr_pf     PF owning the VF under reset
//   vf_flr_vf     VF under reset
//   func_idle     target function has no outstanding traffic (used in DRAIN)
//   busy          FSM active or requests pending
//   err_overflow  sticky: a request was dropped because the queue was full
//   err_timeout   sticky: drain wait expired before func_idle
//   err_bad_func  sticky: request addressed a non-existent PF/VF
module pcie_flr_responder
  import pcie_ss_axis_pkg::*;
#(
  parameter int NUM_PF          = 1,
  parameter int NUM_VF          = 1,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                avl_clk,
  input  logic                rst_n,
  input  t_axis_pcie_flr      flr_req_if,
  output t_axis_pcie_flr      flr_rsp_if,
  output logic [NUM_PF-1:0]   pf_flr_rst_n,
  output logic                vf_flr_rst,
  output logic [FLR_PF_W-1:0] vf_flr_pf,
  output logic [FLR_VF_W-1:0] vf_flr_vf,
  input  logic                func_idle,
  output logic                busy,
  output logic                err_overflow,
  output logic                err_timeout,
  output logic                err_bad_func
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  e_flr_rsp_state    state;
  t_flr_req          req_in;
  t_flr_req          fifo_head;
  t_flr_req          cur_req;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [NUM_PF-1:0] pf_sel;
  logic              unused_rsvd;

  assign req_in      = {flr_req_if.tdata.vf_active, flr_req_if.tdata.vf, flr_req_if.tdata.pf};
  assign unused_rsvd = flr_req_if.tdata.rsvd;

  // Pop only from IDLE, so one request is serviced at a time and the cycle
  // after RESP is the earliest the next head can be taken.
  assign fifo_pop = (state == FLR_IDLE) && !fifo_empty;

  pcie_flr_req_fifo #(
    .WIDTH      (FLR_REQ_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_req_fifo (
    .avl_clk (avl_clk),
    .rst_n   (rst_n),
    .wdata   (req_in),
    .wreq    (flr_req_if.tvalid),
    .rdack   (fifo_pop),
    .rdata   (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // One-hot select of the PF under reset. Built by comparison rather than by
  // indexing so an out-of-range pf can never address a non-existent bit.
  always_comb begin
    pf_sel = '0;
    for (int i = 0; i < NUM_PF; i++) begin
      pf_sel[i] = (int'(cur_req.pf) == i);
    end
  end

  // Outputs are registered from the current state, so the function reset
  // appears one cycle after ASSERT is entered and is released on the same
  // edge that raises the completion pulse.
  always_ff @(posedge avl_clk) begin
    if (!rst_n) begin
      state         <= FLR_IDLE;
      hold_cnt      <= '0;
      tmo_cnt       <= '0;
      flr_rsp_if    <= '0;
      pf_flr_rst_n  <= '1;
      vf_flr_rst    <= 1'b0;
      vf_flr_pf     <= '0;
      vf_flr_vf     <= '0;
      busy          <= 1'b0;
      err_overflow  <= 1'b0;
      err_timeout   <= 1'b0;
      err_bad_func  <= 1'b0;
    end else begin
      flr_rsp_if.tvalid <= 1'b0;
      busy              <= (state != FLR_IDLE) || !fifo_empty;

      if (flr_req_if.tvalid && fifo_full && !fifo_pop) begin
        err_overflow <= 1'b1;
      end

      case (state)
        FLR_IDLE: begin
          if (!fifo_empty) begin
            cur_req <= fifo_head;
            if (flr_func_in_range(fifo_head, NUM_PF, NUM_VF)) begin
              state    <= FLR_ASSERT;
              hold_cnt <= '0;
            end else begin
              // Nothing to reset; acknowledge so the requester is not stranded.
              state        <= FLR_RESP;
              err_bad_func <= 1'b1;
            end
          end
        end

        FLR_ASSERT, FLR_DRAIN: begin
          if (cur_req.vf_active) begin
            vf_flr_rst <= 1'b1;
            vf_flr_pf  <= cur_req.pf;
            vf_flr_vf  <= cur_req.vf;
          end else begin
            pf_flr_rst_n <= ~pf_sel;
          end

          if (state == FLR_ASSERT) begin
            if (hold_cnt == HOLD_LAST) begin
              state   <= FLR_DRAIN;
              tmo_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else begin
            // func_idle is checked first so it wins a tie with the timeout.
            if (func_idle) begin
              state <= FLR_RESP;
            end else if (tmo_cnt == TMO_LAST) begin
              state       <= FLR_RESP;
              err_timeout <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end

        FLR_RESP: begin
          pf_flr_rst_n                <= '1;
          vf_flr_rst                  <= 1'b0;
          vf_flr_pf                   <= '0;
          vf_flr_vf                   <= '0;
          flr_rsp_if.tvalid           <= 1'b1;
          flr_rsp_if.tdata            <= '0;
          flr_rsp_if.tdata.pf         <= cur_req.pf;
          flr_rsp_if.tdata.vf         <= cur_req.vf;
          flr_rsp_if.tdata.vf_active  <= cur_req.vf_active;
          state                       <= FLR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_flr_responder.sv
// Scoreboard bench for pcie_flr_responder: each accepted request pushes its
// expected completion (and, where fixed, the cycle it must appear); the
// monitor pops and compares every completion pulse.
module tb_pcie_flr_responder;
  import pcie_ss_axis_pkg::*;

  localparam int NUM_PF  = 4;
  localparam int NUM_VF  = 8;
  localparam int HOLD    = 16;
  localparam int TMO     = 64;
  localparam int LAT_OK  = HOLD + 4;
  localparam int LAT_BAD = 3;
  localparam int LAT_TMO = HOLD + 3 + TMO;

  typedef struct {
    t_flr_tdata data;
    int         exp_cyc;
  } sb_t;

  logic                avl_clk = 1'b0;
  logic                rst_n;
  t_axis_pcie_flr      flr_req_if;
  t_axis_pcie_flr      flr_rsp_if;
  logic [NUM_PF-1:0]   pf_flr_rst_n;
  logic                vf_flr_rst;
  logic [FLR_PF_W-1:0] vf_flr_pf;
  logic [FLR_VF_W-1:0] vf_flr_vf;
  logic                func_idle;
  logic                busy;
  logic                err_overflow;
  logic                err_timeout;
  logic                err_bad_func;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  sb_t sb[$];

  int                  pf_lo_cnt = 0;
  logic [NUM_PF-1:0]   pf_lo_val = '1;
  int                  vf_hi_cnt = 0;
  logic [FLR_PF_W-1:0] vf_pf_seen = '0;
  logic [FLR_VF_W-1:0] vf_vf_seen = '0;
  int                  multi_rst = 0;
  int                  unexp_rsp = 0;

  pcie_flr_responder #(
    .NUM_PF          (NUM_PF),
    .NUM_VF          (NUM_VF),
    .FIFO_DEPTH_LOG2 (3),
    .HOLD_CYCLES     (HOLD),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .avl_clk      (avl_clk),
    .rst_n        (rst_n),
    .flr_req_if   (flr_req_if),
    .flr_rsp_if   (flr_rsp_if),
    .pf_flr_rst_n (pf_flr_rst_n),
    .vf_flr_rst   (vf_flr_rst),
    .vf_flr_pf    (vf_flr_pf),
    .vf_flr_vf    (vf_flr_vf),
    .func_idle    (func_idle),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout),
    .err_bad_func (err_bad_func)
  );

  always #5 avl_clk = ~avl_clk;

  always @(posedge avl_clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic t_flr_tdata mk_td(input logic [2:0] pf, input logic [10:0] vf,
                                       input logic va, input logic rsvd);
    t_flr_tdata t;
    t.rsvd      = rsvd;
    t.vf_active = va;
    t.vf        = vf;
    t.pf        = pf;
    return t;
  endfunction

  task automatic tick();
    @(posedge avl_clk);
    #1;
  endtask

  // Drives one request beat (caller ends it); pushes the expected completion
  // when the request is expected to be accepted. lat<0 means timing unchecked.
  task automatic drive_req(input logic [2:0] pf, input logic [10:0] vf, input logic va,
                           input logic rsvd, input bit push, input int lat);
    sb_t e;
    flr_req_if.tvalid = 1'b1;
    flr_req_if.tdata  = mk_td(pf, vf, va, rsvd);
    if (push) begin
      e.data    = mk_td(pf, vf, va, 1'b0);
      e.exp_cyc = (lat >= 0) ? cyc + lat : -1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_sb(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge avl_clk);
      n++;
    end
    @(negedge avl_clk);
    check_val("sb_drained", sb.size(), 0);
  endtask

  always @(negedge avl_clk) begin
    sb_t e;
    if (pf_flr_rst_n != '1) begin
      pf_lo_cnt++;
      pf_lo_val = pf_flr_rst_n;
    end
    if (vf_flr_rst) begin
      vf_hi_cnt++;
      vf_pf_seen = vf_flr_pf;
      vf_vf_seen = vf_flr_vf;
    end
    if (($countones(~pf_flr_rst_n) + int'(vf_flr_rst)) > 1) multi_rst++;
    if (flr_rsp_if.tvalid) begin
      if (sb.size() == 0) begin
        unexp_rsp++;
      end else begin
        e = sb.pop_front();
        check_val("rsp_tdata", flr_rsp_if.tdata, e.data);
        if (e.exp_cyc >= 0) check_val("rsp_cycle", cyc, e.exp_cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  pf0;
    int  vf0;
    bit  found;

    rst_n      = 1'b0;
    flr_req_if = '0;
    func_idle  = 1'b1;
    repeat (3) tick();
    @(negedge avl_clk);
    check_val("rst_pf_flr_rst_n", pf_flr_rst_n, 4'hf);
    check_val("rst_vf_flr_rst", vf_flr_rst, 0);
    check_val("rst_vf_flr_pf_vf", {vf_flr_pf, vf_flr_vf}, 0);
    check_val("rst_rsp", flr_rsp_if, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_errs", {err_overflow, err_timeout, err_bad_func}, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // PF FLR pf=1, reserved bit set on the request must not be echoed.
    pf0 = pf_lo_cnt;
    drive_req(3'd1, 11'd0, 1'b0, 1'b1, 1'b1, LAT_OK);
    tick();
    flr_req_if.tvalid = 1'b0;
    repeat (3) tick();
    @(negedge avl_clk);
    check_val("t1_busy", busy, 1);
    wait_sb(60);
    check_val("t1_pf_low_cycles", pf_lo_cnt - pf0, 17);
    check_val("t1_pf_low_value", pf_lo_val, 4'b1101);

    // VF FLR pf=0 vf=5 with func_idle low for 40 cycles.
    tick();
    pf0 = pf_lo_cnt;
    vf0 = vf_hi_cnt;
    func_idle = 1'b0;
    drive_req(3'd0, 11'd5, 1'b1, 1'b0, 1'b1, 42);
    tick();
    flr_req_if.tvalid = 1'b0;
    repeat (39) tick();
    func_idle = 1'b1;
    wait_sb(20);
    check_val("t2_vf_hi_cycles", vf_hi_cnt - vf0, 39);
    check_val("t2_vf_pf", vf_pf_seen, 0);
    check_val("t2_vf_vf", vf_vf_seen, 5);
    check_val("t2_pf_untouched", pf_lo_cnt - pf0, 0);
    check_val("t2_errs", {err_overflow, err_timeout, err_bad_func}, 0);

    // Out-of-range requests: pf=7, then VF 9 with NUM_VF=8.
    tick();
    pf0 = pf_lo_cnt;
    vf0 = vf_hi_cnt;
    drive_req(3'd7, 11'd0, 1'b0, 1'b0, 1'b1, LAT_BAD);
    tick();
    flr_req_if.tvalid = 1'b0;
    wait_sb(10);
    check_val("t5_bad_func", err_bad_func, 1);
    tick();
    drive_req(3'd0, 11'd9, 1'b1, 1'b0, 1'b1, LAT_BAD);
    tick();
    flr_req_if.tvalid = 1'b0;
    wait_sb(10);
    check_val("t5_no_reset", (pf_lo_cnt - pf0) + (vf_hi_cnt - vf0), 0);

    // Drain timeout with func_idle stuck low.
    tick();
    func_idle = 1'b0;
    drive_req(3'd2, 11'd0, 1'b0, 1'b0, 1'b1, LAT_TMO);
    tick();
    flr_req_if.tvalid = 1'b0;
    repeat (60) tick();
    @(negedge avl_clk);
    check_val("t3_tmo_not_yet", err_timeout, 0);
    wait_sb(60);
    check_val("t3_err_timeout", err_timeout, 1);

    // Burst of 10 while busy: 8 queued, 2 dropped; one more sent on the pop cycle.
    tick();
    drive_req(3'd2, 11'd0, 1'b0, 1'b0, 1'b1, -1);
    tick();
    flr_req_if.tvalid = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drive_req(3'(i % 4), 11'd0, 1'b0, 1'b0, i < 8, -1);
      else            drive_req(3'(i % 4), 11'(i % 8), 1'b1, 1'b0, i < 8, -1);
      tick();
    end
    flr_req_if.tvalid = 1'b0;
    tick();
    @(negedge avl_clk);
    check_val("t4_err_overflow", err_overflow, 1);
    check_val("t4_timeout_sticky", err_timeout, 1);
    func_idle = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge avl_clk);
      if (flr_rsp_if.tvalid) found = 1'b1;
    end
    check_val("t4_first_rsp_seen", found, 1);
    drive_req(3'd3, 11'd7, 1'b1, 1'b0, 1'b1, -1);
    tick();
    flr_req_if.tvalid = 1'b0;
    wait_sb(400);

    // Reset while in DRAIN abandons the FLR.
    tick();
    func_idle = 1'b0;
    drive_req(3'd3, 11'd0, 1'b0, 1'b0, 1'b0, -1);
    tick();
    flr_req_if.tvalid = 1'b0;
    repeat (24) tick();
    @(negedge avl_clk);
    check_val("t6_pf3_in_reset", pf_flr_rst_n, 4'b0111);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge avl_clk);
    check_val("t6_pf_released", pf_flr_rst_n, 4'hf);
    check_val("t6_vf_released", vf_flr_rst, 0);
    check_val("t6_busy", busy, 0);
    check_val("t6_errs_cleared", {err_overflow, err_timeout, err_bad_func}, 0);
    func_idle = 1'b1;
    repeat (30) tick();
    drive_req(3'd0, 11'd0, 1'b0, 1'b0, 1'b1, LAT_OK);
    tick();
    flr_req_if.tvalid = 1'b0;
    wait_sb(60);

    check_val("unexpected_rsp", unexp_rsp, 0);
    check_val("multi_reset", multi_rst, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
